// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit with HI/LO registers.
// Results land in HI/LO on the edge that busy falls.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] MDUOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   thi;
  logic [31:0]   tlo;
  logic          twr;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] bu_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;

  logic is_mul;
  logic is_mulu;
  logic is_div;
  logic is_divu;
  logic is_mthi;
  logic is_mtlo;

  // Full-width products and quotients from the live operands.
  // Signed divide goes through magnitudes so that
  // 0x80000000 / -1 wraps cleanly to 0x80000000.
  always_comb begin
    prod_s  = $signed({{32{A[31]}}, A})
            * $signed({{32{B[31]}}, B});
    prod_u  = {32'd0, A} * {32'd0, B};
    a_mag   = A[31] ? (32'd0 - A) : A;
    b_mag   = B[31] ? (32'd0 - B) : B;
    b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    bu_safe = (B == 32'd0) ? 32'd1 : B;
    q_mag   = a_mag / b_safe;
    r_mag   = a_mag % b_safe;
    q_s     = (A[31] ^ B[31]) ? (32'd0 - q_mag) : q_mag;
    r_s     = A[31] ? (32'd0 - r_mag) : r_mag;
    q_u     = A / bu_safe;
    r_u     = A % bu_safe;
  end

  // One-hot request decode; anything else is a no-op.
  always_comb begin
    is_mul  = start && (MDUOp == OP_MULT);
    is_mulu = start && (MDUOp == OP_MULTU);
    is_div  = start && (MDUOp == OP_DIV);
    is_divu = start && (MDUOp == OP_DIVU);
    is_mthi = start && (MDUOp == OP_MTHI);
    is_mtlo = start && (MDUOp == OP_MTLO);
  end

  // Read port tracks the registered HI/LO directly.
  always_comb begin
    MDUOut = 32'd0;
    if (MDUOp == OP_MFHI) MDUOut = HI;
    else if (MDUOp == OP_MFLO) MDUOut = LO;
  end

  // Launch/run/commit FSM; busy is registered with the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      thi   <= 32'd0;
      tlo   <= 32'd0;
      twr   <= 1'b0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          unique case (1'b1)
            is_mul: begin
              {thi, tlo} <= prod_s;
              twr   <= 1'b1;
              cnt   <= CW'(MULT_CYCLES);
              state <= RUN;
              busy  <= 1'b1;
            end
            is_mulu: begin
              {thi, tlo} <= prod_u;
              twr   <= 1'b1;
              cnt   <= CW'(MULT_CYCLES);
              state <= RUN;
              busy  <= 1'b1;
            end
            is_div: begin
              thi   <= r_s;
              tlo   <= q_s;
              twr   <= (B != 32'd0);
              cnt   <= CW'(DIV_CYCLES);
              state <= RUN;
              busy  <= 1'b1;
            end
            is_divu: begin
              thi   <= r_u;
              tlo   <= q_u;
              twr   <= (B != 32'd0);
              cnt   <= CW'(DIV_CYCLES);
              state <= RUN;
              busy  <= 1'b1;
            end
            is_mthi: HI <= A;
            is_mtlo: LO <= A;
            default: ;
          endcase
        end
        RUN: begin
          if (cnt == CW'(1)) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            if (twr) begin
              HI <= thi;
              LO <= tlo;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: E_MDU

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (reset==0 at a rising edge clears state).
REQ-005 SHALL have port start  input  1  one-cycle request to launch the operation on MDUOp.
REQ-006 SHALL have port MDUOp  input  4  op select: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; others = NONE.
REQ-007 SHALL have port A  input  32  rs operand (multiplicand / dividend / MT source).
REQ-008 SHALL have port B  input  32  rt operand (multiplier / divisor).
REQ-009 SHALL have port busy  output  1  high while a mult/div is in flight.
REQ-010 SHALL have port MDUOut  output  32  read data for MFHI/MFLO.
REQ-011 SHALL have ports HI, LO  output  32 each  architectural HI/LO registers.

Function
REQ-012 SHALL accept a mult/div launch only when start==1, busy==0, MDUOp in {1..4}; otherwise start is ignored for launch.
REQ-013 SHALL, on launch edge, compute the full result from A,B into internal temp registers; HI/LO unchanged until commit.
REQ-014 SHALL raise busy on the edge after launch and hold it for exactly MULT_CYCLES (mult) or DIV_CYCLES (div) cycles, via a down-counter loaded at launch.
REQ-015 SHALL, on the edge where counter reaches zero, copy temp into HI/LO and drop busy in the same edge; HI/LO visible with busy==0.
REQ-016 SHALL keep a two-state FSM: IDLE (busy=0), RUN (busy=1, counter>0); IDLE->RUN on launch; RUN->IDLE on commit; no other transitions except reset.
REQ-017 SHALL for MULT produce {HI,LO} = signed(A)*signed(B), 64-bit; MULTU unsigned 64-bit product.
REQ-018 SHALL for DIV set LO = signed quotient truncated toward zero, HI = remainder with sign of dividend; DIVU unsigned quotient/remainder.
REQ-019 SHALL for DIV 0x80000000 / 0xFFFFFFFF produce LO=0x80000000, HI=0 (wrap, no trap).
REQ-020 SHALL for divide by zero (B==0, DIV or DIVU) run the full DIV_CYCLES with busy and leave HI and LO unchanged at commit.
REQ-021 SHALL for MTHI/MTLO with start==1 and busy==0 write A into HI/LO on that edge; no busy assertion.
REQ-022 SHALL ignore MTHI/MTLO while busy==1 (pipeline stall owns this; block must not corrupt temp or HI/LO).
REQ-023 SHALL drive MDUOut combinationally: HI when MDUOp==MFHI, LO when MDUOp==MFLO, else 0; value reflects current registered HI/LO regardless of start/busy.
REQ-024 SHALL ignore a new start arriving on the commit edge (busy still 1); a launch needs busy==0 at sampling edge.
REQ-025 SHALL treat MDUOp NONE or MFHI/MFLO with start==1 as no state change.

Reset
REQ-026 SHALL on reset==0 at an edge clear HI, LO, temp, counter to 0, FSM to IDLE, busy to 0, overriding any simultaneous start.
REQ-027 SHALL abort an in-flight operation on reset with no commit; first launch permitted on the edge after reset releases.

Verification
REQ-028 SHALL pass: MULT A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-029 SHALL pass: DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7,B=2 -> LO=3, HI=1.
REQ-030 SHALL pass: HI=0x11, LO=0x22 preset by MTHI/MTLO, then DIVU B=0 -> busy 10 cycles, HI=0x11, LO=0x22 after.
REQ-031 SHALL pass: MULT launched, second start (MTLO A=0x55) during busy and on commit edge -> both ignored, LO = product only.
REQ-032 SHALL pass: DIV launched, reset=0 on 4th busy cycle -> next edge busy=0, HI=LO=0, no later commit.
REQ-033 SHALL pass: MTHI A=0xDEADBEEF then MDUOp=MFHI next cycle -> MDUOut=0xDEADBEEF, busy stays 0.
